// File: rtl/sm_mcu_vs_swap_ctrl.sv
// rtl/sm_mcu_vs_swap_ctrl.sv - VS-synchronised double-buffer swap controller with Avalon-MM slave
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   address[1:0]        register select: 0 CTRL, 1 FRAME, 2 MASK, 3 EVENT
//   chipselect, write_n Avalon-MM slave select and active-low write strobe
//   writedata[31:0]     write data
//   readdata[31:0]      registered read data, one cycle after address
//   irq                 |(event & mask)
//   vs_in               raw asynchronous vertical sync from panel timing
//   buf_sel             framebuffer currently scanned out
//   swap_pulse          one-cycle strobe in the cycle the swap is committed
module sm_mcu_vs_swap_ctrl #(
    parameter int CNT_W        = 16,
    parameter int IVL_W        = 4,
    parameter int EDGE_FALLING = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    input  logic        vs_in,
    output logic        buf_sel,
    output logic        swap_pulse
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_SWAP  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state;
    logic               vs_d1;
    logic               vs_d2;
    logic               vs_edge;
    logic [CNT_W-1:0]   frame_cnt;
    logic [IVL_W-1:0]   interval;
    logic [IVL_W-1:0]   wait_cnt;
    logic [IVL_W-1:0]   load_cnt;
    logic [1:0]         irq_mask;
    logic [1:0]         event_r;
    logic [1:0]         event_clr;
    logic [1:0]         event_set;
    logic               wr;
    logic               arm_wr;
    logic               busy;
    logic               unused_ok;

    // vs_edge is decoded from the two synchroniser flops, so it is high for
    // exactly one cycle right after the new VS level lands in vs_d1.
    assign vs_edge = (EDGE_FALLING != 0) ? (~vs_d1 & vs_d2) : (vs_d1 & ~vs_d2);

    assign wr       = chipselect & ~write_n;
    assign arm_wr   = wr && (address == 2'd0) && writedata[0];
    assign busy     = (state != S_IDLE);
    assign load_cnt = (interval == '0) ? IVL_W'(1) : interval;

    // Hardware set beats a simultaneous software clear, so no event is lost.
    assign event_clr = (wr && (address == 2'd3)) ? writedata[1:0] : 2'b00;
    assign event_set = {vs_edge, (state == S_SWAP)};

    assign irq = |(event_r & irq_mask);

    assign unused_ok = &{1'b0, writedata[31:IVL_W]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            vs_d1      <= 1'b0;
            vs_d2      <= 1'b0;
            frame_cnt  <= '0;
            interval   <= '0;
            wait_cnt   <= '0;
            irq_mask   <= 2'b00;
            event_r    <= 2'b00;
            buf_sel    <= 1'b0;
            swap_pulse <= 1'b0;
            readdata   <= 32'd0;
        end else begin
            vs_d1 <= vs_in;
            vs_d2 <= vs_d1;

            if (vs_edge) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end

            if (wr && (address == 2'd1)) begin
                interval <= writedata[IVL_W-1:0];
            end
            if (wr && (address == 2'd2)) begin
                irq_mask <= writedata[1:0];
            end

            event_r <= (event_r & ~event_clr) | event_set;

            swap_pulse <= 1'b0;

            case (state)
                S_IDLE: begin
                    // An edge in the arming cycle is not counted: we are
                    // still idle when it is seen.
                    if (arm_wr) begin
                        state    <= S_ARMED;
                        wait_cnt <= load_cnt;
                    end
                end
                S_ARMED: begin
                    if (vs_edge) begin
                        wait_cnt <= wait_cnt - IVL_W'(1);
                        if (wait_cnt == IVL_W'(1)) begin
                            state      <= S_SWAP;
                            swap_pulse <= 1'b1;
                        end
                    end
                end
                S_SWAP: begin
                    state   <= S_DONE;
                    buf_sel <= ~buf_sel;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            case (address)
                2'd0:    readdata <= {29'd0, buf_sel, busy, 1'b0};
                2'd1:    readdata <= 32'(frame_cnt);
                2'd2:    readdata <= {30'd0, irq_mask};
                default: readdata <= {30'd0, event_r};
            endcase
        end
    end

endmodule

// File: tb/tb_sm_mcu_vs_swap_ctrl.sv
// tb/tb_sm_mcu_vs_swap_ctrl.sv - directed self-checking bench for sm_mcu_vs_swap_ctrl
module tb_sm_mcu_vs_swap_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic        vs_in;
    logic        buf_sel;
    logic        swap_pulse;

    int checks = 0;
    int errors = 0;
    int exp_frame = 0;

    always #5 clk = ~clk;

    // Narrow frame counter keeps the wrap point reachable in a short run.
    sm_mcu_vs_swap_ctrl #(
        .CNT_W(8),
        .IVL_W(4),
        .EDGE_FALLING(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .irq(irq),
        .vs_in(vs_in),
        .buf_sel(buf_sel),
        .swap_pulse(swap_pulse)
    );

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    // One falling VS edge; reports swap_pulse count and first cycle index.
    task automatic vs_pulse(output int pulses, output int first);
        pulses = 0;
        first  = -1;
        @(negedge clk);
        vs_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (swap_pulse === 1'b1) begin
                if (first < 0) first = i;
                pulses++;
            end
        end
        vs_in = 1'b1;
        repeat (3) @(negedge clk);
        exp_frame = (exp_frame + 1) % 256;
    endtask

    task automatic vs_fast(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vs_in = 1'b0;
            @(negedge clk);
            vs_in = 1'b1;
        end
        repeat (3) @(negedge clk);
        exp_frame = (exp_frame + n) % 256;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rd_reg(2'(a), rd);
            checks++;
            if (rd !== 32'd0) begin
                errors++;
                $display("FAIL reset_read addr %0d got %08h exp 00000000", a, rd);
            end
        end
        checks++;
        if (buf_sel !== 1'b0) begin
            errors++;
            $display("FAIL reset_buf_sel got %b exp 0", buf_sel);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq got %b exp 0", irq);
        end
        checks++;
        if (swap_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_swap_pulse got %b exp 0", swap_pulse);
        end
    endtask

    task automatic test_swap_basic;
        logic [31:0] rd;
        int p, f;
        wr_reg(2'd1, 32'd1);
        wr_reg(2'd2, 32'd1);
        wr_reg(2'd0, 32'd1);
        rd_reg(2'd0, rd);
        checks++;
        if (rd !== 32'd2) begin
            errors++;
            $display("FAIL basic_busy got %08h exp 00000002", rd);
        end
        vs_pulse(p, f);
        checks++;
        if (p !== 1) begin
            errors++;
            $display("FAIL basic_pulse_count got %0d exp 1", p);
        end
        checks++;
        if (f !== 1) begin
            errors++;
            $display("FAIL basic_pulse_latency got %0d exp 1", f);
        end
        checks++;
        if (buf_sel !== 1'b1) begin
            errors++;
            $display("FAIL basic_buf_sel got %b exp 1", buf_sel);
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL basic_irq got %b exp 1", irq);
        end
        rd_reg(2'd3, rd);
        checks++;
        if (rd !== 32'd3) begin
            errors++;
            $display("FAIL basic_event got %08h exp 00000003", rd);
        end
        wr_reg(2'd3, 32'd1);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL basic_irq_clear got %b exp 0", irq);
        end
        rd_reg(2'd3, rd);
        checks++;
        if (rd !== 32'd2) begin
            errors++;
            $display("FAIL basic_event_w1c got %08h exp 00000002", rd);
        end
        rd_reg(2'd0, rd);
        checks++;
        if (rd !== 32'd4) begin
            errors++;
            $display("FAIL basic_ctrl_after got %08h exp 00000004", rd);
        end
    endtask

    task automatic test_interval3;
        logic [31:0] rd;
        int p, f, total;
        total = 0;
        wr_reg(2'd1, 32'd3);
        wr_reg(2'd0, 32'd1);
        vs_pulse(p, f);
        total += p;
        checks++;
        if (p !== 0) begin
            errors++;
            $display("FAIL ivl3_edge1 got %0d exp 0", p);
        end
        wr_reg(2'd0, 32'd1);
        vs_pulse(p, f);
        total += p;
        checks++;
        if (p !== 0) begin
            errors++;
            $display("FAIL ivl3_edge2 got %0d exp 0", p);
        end
        vs_pulse(p, f);
        total += p;
        checks++;
        if (p !== 1) begin
            errors++;
            $display("FAIL ivl3_edge3 got %0d exp 1", p);
        end
        checks++;
        if (total !== 1) begin
            errors++;
            $display("FAIL ivl3_total got %0d exp 1", total);
        end
        checks++;
        if (buf_sel !== 1'b0) begin
            errors++;
            $display("FAIL ivl3_buf_sel got %b exp 0", buf_sel);
        end
        rd_reg(2'd1, rd);
        checks++;
        if (rd !== 32'(exp_frame)) begin
            errors++;
            $display("FAIL ivl3_frame got %08h exp %08h", rd, exp_frame);
        end
    endtask

    task automatic test_interval0_wrap;
        logic [31:0] rd;
        int p, f;
        wr_reg(2'd1, 32'd0);
        wr_reg(2'd0, 32'd1);
        vs_pulse(p, f);
        checks++;
        if (p !== 1 || f !== 1) begin
            errors++;
            $display("FAIL ivl0_swap got count %0d at %0d exp count 1 at 1", p, f);
        end
        checks++;
        if (buf_sel !== 1'b1) begin
            errors++;
            $display("FAIL ivl0_buf_sel got %b exp 1", buf_sel);
        end
        vs_fast(255 - exp_frame);
        rd_reg(2'd1, rd);
        checks++;
        if (rd !== 32'h000000FF) begin
            errors++;
            $display("FAIL wrap_pre got %08h exp 000000ff", rd);
        end
        vs_fast(1);
        rd_reg(2'd1, rd);
        checks++;
        if (rd !== 32'h00000000) begin
            errors++;
            $display("FAIL wrap_post got %08h exp 00000000", rd);
        end
    endtask

    task automatic test_coincident;
        logic [31:0] rd;
        int p, f;
        wr_reg(2'd3, 32'd3);
        rd_reg(2'd3, rd);
        checks++;
        if (rd !== 32'd0) begin
            errors++;
            $display("FAIL coin_clear_all got %08h exp 00000000", rd);
        end
        wr_reg(2'd3, 32'd0);
        vs_fast(1);
        // Edge strobe and W1C of bit1 land in the same cycle.
        @(negedge clk);
        vs_in = 1'b0;
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 2'd3;
        writedata  = 32'd2;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        exp_frame  = (exp_frame + 1) % 256;
        @(negedge clk);
        vs_in = 1'b1;
        repeat (2) @(negedge clk);
        rd_reg(2'd3, rd);
        checks++;
        if (rd !== 32'd2) begin
            errors++;
            $display("FAIL coin_set_wins got %08h exp 00000002", rd);
        end
        wr_reg(2'd3, 32'd2);
        rd_reg(2'd3, rd);
        checks++;
        if (rd !== 32'd0) begin
            errors++;
            $display("FAIL coin_w1c_alone got %08h exp 00000000", rd);
        end
        // Arm write and edge strobe in the same cycle.
        wr_reg(2'd1, 32'd1);
        @(negedge clk);
        vs_in = 1'b0;
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 2'd0;
        writedata  = 32'd1;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        exp_frame  = (exp_frame + 1) % 256;
        p = 0;
        for (int i = 0; i < 6; i++) begin
            if (swap_pulse === 1'b1) p++;
            @(negedge clk);
        end
        checks++;
        if (p !== 0) begin
            errors++;
            $display("FAIL coin_arm_edge_counted got %0d pulses exp 0", p);
        end
        vs_in = 1'b1;
        repeat (2) @(negedge clk);
        rd_reg(2'd0, rd);
        checks++;
        if (rd !== 32'd6) begin
            errors++;
            $display("FAIL coin_arm_busy got %08h exp 00000006", rd);
        end
        vs_pulse(p, f);
        checks++;
        if (p !== 1) begin
            errors++;
            $display("FAIL coin_next_edge got %0d exp 1", p);
        end
        checks++;
        if (buf_sel !== 1'b0) begin
            errors++;
            $display("FAIL coin_buf_sel got %b exp 0", buf_sel);
        end
        rd_reg(2'd1, rd);
        checks++;
        if (rd !== 32'(exp_frame)) begin
            errors++;
            $display("FAIL coin_frame got %08h exp %08h", rd, exp_frame);
        end
    endtask

    task automatic test_reset_abort;
        logic [31:0] rd;
        int p, f;
        wr_reg(2'd1, 32'd1);
        wr_reg(2'd0, 32'd1);
        vs_pulse(p, f);
        checks++;
        if (buf_sel !== 1'b1) begin
            errors++;
            $display("FAIL abort_setup_buf_sel got %b exp 1", buf_sel);
        end
        wr_reg(2'd1, 32'd2);
        wr_reg(2'd0, 32'd1);
        vs_pulse(p, f);
        rd_reg(2'd0, rd);
        checks++;
        if (rd !== 32'd6 || p !== 0) begin
            errors++;
            $display("FAIL abort_armed got ctrl %08h pulses %0d exp 00000006 0", rd, p);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_frame = 0;
        checks++;
        if (buf_sel !== 1'b0) begin
            errors++;
            $display("FAIL abort_buf_sel got %b exp 0", buf_sel);
        end
        rd_reg(2'd0, rd);
        checks++;
        if (rd !== 32'd0) begin
            errors++;
            $display("FAIL abort_ctrl got %08h exp 00000000", rd);
        end
        vs_pulse(p, f);
        checks++;
        if (p !== 0) begin
            errors++;
            $display("FAIL abort_no_swap got %0d exp 0", p);
        end
        rd_reg(2'd1, rd);
        checks++;
        if (rd !== 32'(exp_frame)) begin
            errors++;
            $display("FAIL abort_frame got %08h exp %08h", rd, exp_frame);
        end
    endtask

    initial begin
        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = 32'd0;
        vs_in      = 1'b1;
        test_reset;
        test_swap_basic;
        test_interval3;
        test_interval0_wrap;
        test_coincident;
        test_reset_abort;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
